// File: rtl/seq_restoring_divider_if.sv
// Operand/result bundle for the sequential restoring divider.
// Handshake: start is a one-cycle request; done pulses once when quotient/remainder are valid.
interface seq_restoring_divider_if #(
    parameter int WIDTH = 6
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    logic             overflow;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero, overflow
    );
endinterface

// File: rtl/seq_restoring_divider.sv
// Multi-cycle restoring divider: one trial subtraction per clock, results held until the next run.
// Define SIGNED_DIV_EN for two's-complement operands (adds a sign fix-up cycle).
module seq_restoring_divider #(
    parameter int WIDTH = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    seq_restoring_divider_if.slave  bus,
    output logic [2:0]              state_dbg
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0]    LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RUN  = 3'd1,
        S_ZERO = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] dq;        // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] dnd_orig;
    logic [WIDTH:0]   rem_acc;
    logic [CW-1:0]    cnt;

    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             dbz_q;

    logic             accept;
    logic             last;
    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   r_next;
    logic [WIDTH-1:0] dq_next;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

`ifdef SIGNED_DIV_EN
    logic q_neg;
    logic r_neg;
    logic ovf_pend;
    logic ovf_q;

    assign mag_a = bus.dividend[WIDTH-1] ? (~bus.dividend + ONE) : bus.dividend;
    assign mag_b = bus.divisor[WIDTH-1]  ? (~bus.divisor + ONE)  : bus.divisor;
    assign bus.overflow = ovf_q;
`else
    assign mag_a = bus.dividend;
    assign mag_b = bus.divisor;
    assign bus.overflow = 1'b0;
`endif

    assign accept = bus.start && (state == S_IDLE || state == S_DONE);
    assign last   = (cnt == LAST);

    always_comb begin
        r_shift = {rem_acc[WIDTH-1:0], dq[WIDTH-1]};
        trial   = r_shift - {1'b0, dvs};
        r_next  = r_shift;
        dq_next = {dq[WIDTH-2:0], 1'b0};
        // No borrow out of the trial subtraction means the divisor fits.
        if (!trial[WIDTH]) begin
            r_next  = trial;
            dq_next = {dq[WIDTH-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_next = (bus.divisor == '0) ? S_ZERO : S_RUN;
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_RUN: begin
                if (last) begin
`ifdef SIGNED_DIV_EN
                    state_next = S_FIX;
`else
                    state_next = S_DONE;
`endif
                end
            end
            S_ZERO:  state_next = S_DONE;
            S_FIX:   state_next = S_DONE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dq          <= '0;
            dvs         <= '0;
            dnd_orig    <= '0;
            rem_acc     <= '0;
            cnt         <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
`ifdef SIGNED_DIV_EN
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            ovf_pend    <= 1'b0;
            ovf_q       <= 1'b0;
`endif
        end else if (accept) begin
            dq       <= mag_a;
            dvs      <= mag_b;
            dnd_orig <= bus.dividend;
            rem_acc  <= '0;
            cnt      <= '0;
`ifdef SIGNED_DIV_EN
            q_neg    <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
            r_neg    <= bus.dividend[WIDTH-1];
            ovf_pend <= (bus.dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.divisor == '1);
`endif
        end else begin
            case (state)
                S_RUN: begin
                    rem_acc <= r_next;
                    dq      <= dq_next;
                    cnt     <= cnt + CW'(1);
`ifndef SIGNED_DIV_EN
                    if (last) begin
                        quotient_q  <= dq_next;
                        remainder_q <= r_next[WIDTH-1:0];
                        dbz_q       <= 1'b0;
                    end
`endif
                end
                S_ZERO: begin
                    quotient_q  <= '1;
                    remainder_q <= dnd_orig;
                    dbz_q       <= 1'b1;
`ifdef SIGNED_DIV_EN
                    ovf_q       <= 1'b0;
`endif
                end
`ifdef SIGNED_DIV_EN
                S_FIX: begin
                    quotient_q  <= q_neg ? (~dq + ONE) : dq;
                    remainder_q <= r_neg ? (~rem_acc[WIDTH-1:0] + ONE) : rem_acc[WIDTH-1:0];
                    dbz_q       <= 1'b0;
                    ovf_q       <= ovf_pend;
                end
`endif
                default: ;
            endcase
        end
    end

    assign bus.busy        = (state == S_RUN) || (state == S_FIX);
    assign bus.done        = (state == S_DONE);
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dbz_q;
    assign state_dbg       = state;
endmodule
